// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar ping sequencer.
// The state enum is used by the top-level FSM; DW/CW are the default widths.
package sonar_pkg;

  localparam int DW_DEF  = 8;
  localparam int CW_DEF  = 12;
  localparam int MIN_DIV = 2;

  typedef enum logic [2:0] {
    PING_IDLE   = 3'd0,
    PING_TX     = 3'd1,
    PING_BLANK  = 3'd2,
    PING_LISTEN = 3'd3,
    PING_DONE   = 3'd4
  } ping_state_e;

endpackage

// File: rtl/sonar_ping_sequencer_tick_gen.sv
// Sample-rate strobe: divides clk by div_c, held at zero while clr is high.
// tick_next is the lookahead of tick so callers can build registered strobes aligned to tick.
module tick_gen
  import sonar_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] div_c,
  output logic          tick,
  output logic          tick_next
);

  logic [DW-1:0] cnt_r;
  logic [DW-1:0] cnt_nxt_s;
  logic [DW-1:0] div_m1_s;
  logic          tick_r;

  assign div_m1_s  = div_c - DW'(1'b1);
  assign tick_next = (cnt_nxt_s == div_m1_s);
  assign tick      = tick_r;

  // next count: restart on clr, wrap at div_c-1
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == div_m1_s) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + DW'(1'b1);
    end
  end

  // count register and registered tick, high while the count sits at div_c-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_next;
    end
  end

endmodule

// File: rtl/sonar_ping_sequencer.sv
// One sonar ping: TX burst, blanking, then a listen window that strobes PCM writes per tick.
// All outputs are registered from the next state so they line up with the state they describe.
module sonar_ping_sequencer
  import sonar_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] div_c,
  input  logic [CW-1:0] tx_len,
  input  logic [CW-1:0] blank_len,
  input  logic [CW-1:0] listen_len,
  output logic          busy,
  output logic          tx_en,
  output logic          listen_en,
  output logic          sample_we,
  output logic [CW-1:0] sample_idx,
  output logic          done,
  output logic          err_cfg
);

  ping_state_e   state_r, nxt_s, first_s;
  logic [DW-1:0] div_r;
  logic [CW-1:0] tx_len_r, blank_len_r, listen_len_r;
  logic [CW-1:0] phase_r, phase_nxt_s, len_s;
  logic          tick_s, tick_next_s, clr_s;
  logic          cfg_ok_s, accept_s, last_s;
  logic          busy_nxt_s, tx_nxt_s, listen_nxt_s, we_nxt_s, done_nxt_s, err_nxt_s;
  logic [CW-1:0] idx_nxt_s;
  logic          busy_r, tx_en_r, listen_en_r, sample_we_r, done_r, err_cfg_r;
  logic [CW-1:0] sample_idx_r;

  // Counter is pinned at zero in IDLE, so every ping starts with a fresh tick period.
  assign clr_s = (state_r == PING_IDLE);

  tick_gen #(.DW(DW)) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_s),
    .div_c     (div_r),
    .tick      (tick_s),
    .tick_next (tick_next_s)
  );

  assign cfg_ok_s = (div_c >= DW'(MIN_DIV)) && (listen_len != '0);
  assign accept_s = (state_r == PING_IDLE) && start && !abort && cfg_ok_s;
  assign last_s   = tick_s && (phase_r == len_s - CW'(1'b1));

  // length of the phase currently running
  always_comb begin
    len_s = '0;
    case (state_r)
      PING_TX:     len_s = tx_len_r;
      PING_BLANK:  len_s = blank_len_r;
      PING_LISTEN: len_s = listen_len_r;
      default:     len_s = '0;
    endcase
  end

  // first non-empty phase of a freshly accepted ping
  always_comb begin
    first_s = PING_LISTEN;
    if (tx_len != '0) begin
      first_s = PING_TX;
    end else if (blank_len != '0) begin
      first_s = PING_BLANK;
    end else begin
      first_s = PING_LISTEN;
    end
  end

  // next-state logic; abort overrides everything
  always_comb begin
    nxt_s = state_r;
    if (abort) begin
      nxt_s = PING_IDLE;
    end else begin
      case (state_r)
        PING_IDLE:   nxt_s = accept_s ? first_s : PING_IDLE;
        PING_TX:     nxt_s = last_s ? ((blank_len_r != '0) ? PING_BLANK : PING_LISTEN) : PING_TX;
        PING_BLANK:  nxt_s = last_s ? PING_LISTEN : PING_BLANK;
        PING_LISTEN: nxt_s = last_s ? PING_DONE : PING_LISTEN;
        PING_DONE:   nxt_s = PING_IDLE;
        default:     nxt_s = PING_IDLE;
      endcase
    end
  end

  // phase counter: ticks within the current phase, cleared between phases
  always_comb begin
    phase_nxt_s = phase_r;
    if (abort || (state_r == PING_IDLE) || (state_r == PING_DONE)) begin
      phase_nxt_s = '0;
    end else if (last_s) begin
      phase_nxt_s = '0;
    end else if (tick_s) begin
      phase_nxt_s = phase_r + CW'(1'b1);
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Moore outputs decoded from the next state; the sample strobe uses the tick lookahead
  always_comb begin
    busy_nxt_s   = (nxt_s != PING_IDLE);
    tx_nxt_s     = (nxt_s == PING_TX);
    listen_nxt_s = (nxt_s == PING_LISTEN);
    done_nxt_s   = (nxt_s == PING_DONE);
    we_nxt_s     = (nxt_s == PING_LISTEN) && tick_next_s;
    err_nxt_s    = (state_r == PING_IDLE) && start && !abort && !cfg_ok_s;
    idx_nxt_s    = sample_idx_r;
    if (abort) begin
      idx_nxt_s = '0;
    end else if (we_nxt_s) begin
      idx_nxt_s = phase_nxt_s;
    end else begin
      idx_nxt_s = sample_idx_r;
    end
  end

  // state and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PING_IDLE;
      phase_r <= '0;
    end else begin
      state_r <= nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // configuration captured only when a ping is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r        <= '0;
      tx_len_r     <= '0;
      blank_len_r  <= '0;
      listen_len_r <= '0;
    end else if (accept_s) begin
      div_r        <= div_c;
      tx_len_r     <= tx_len;
      blank_len_r  <= blank_len;
      listen_len_r <= listen_len;
    end
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      tx_en_r      <= 1'b0;
      listen_en_r  <= 1'b0;
      sample_we_r  <= 1'b0;
      done_r       <= 1'b0;
      err_cfg_r    <= 1'b0;
      sample_idx_r <= '0;
    end else begin
      busy_r       <= busy_nxt_s;
      tx_en_r      <= tx_nxt_s;
      listen_en_r  <= listen_nxt_s;
      sample_we_r  <= we_nxt_s;
      done_r       <= done_nxt_s;
      err_cfg_r    <= err_nxt_s;
      sample_idx_r <= idx_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign tx_en      = tx_en_r;
  assign listen_en  = listen_en_r;
  assign sample_we  = sample_we_r;
  assign sample_idx = sample_idx_r;
  assign done       = done_r;
  assign err_cfg    = err_cfg_r;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Bench for sonar_ping_sequencer: directed and random pings checked cycle by cycle
// against a timeline model derived from phase lengths times the divider.
module tb_sonar_ping_sequencer;

  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] div_c = '0;
  logic [CW-1:0] tx_len = '0;
  logic [CW-1:0] blank_len = '0;
  logic [CW-1:0] listen_len = '0;
  logic          busy, tx_en, listen_en, sample_we, done, err_cfg;
  logic [CW-1:0] sample_idx;

  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_idx = '0;

  always #5 clk = ~clk;

  sonar_ping_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .div_c      (div_c),
    .tx_len     (tx_len),
    .blank_len  (blank_len),
    .listen_len (listen_len),
    .busy       (busy),
    .tx_en      (tx_en),
    .listen_en  (listen_en),
    .sample_we  (sample_we),
    .sample_idx (sample_idx),
    .done       (done),
    .err_cfg    (err_cfg)
  );

  function automatic logic [31:0] pack(input logic b, input logic t, input logic l,
                                       input logic w, input logic d, input logic e,
                                       input logic [CW-1:0] idx);
    return {14'd0, b, t, l, w, d, e, idx};
  endfunction

  function automatic logic [31:0] obs();
    return pack(busy, tx_en, listen_en, sample_we, done, err_cfg, sample_idx);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h (busy,tx,listen,we,done,err,idx)", tag, got, want);
    end
  endtask

  // Runs one ping from IDLE. abort_t<0 means no abort; abort is held during cycle abort_t.
  // ign adds stray start pulses while busy, always including the done cycle.
  task automatic run_ping(input string name, input int d, input int tx, input int bl,
                          input int li, input int abort_t, input bit ign);
    int   tt, bb, ll, endt, last, k;
    logic b, t_, l, w, dn;
    tt   = tx * d;
    bb   = bl * d;
    ll   = li * d;
    endt = tt + bb + ll;
    last = (abort_t >= 0) ? abort_t + 1 : endt + 1;
    @(negedge clk);
    check($sformatf("%s_idle", name), obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_idx));
    div_c      = DW'(d);
    tx_len     = CW'(tx);
    blank_len  = CW'(bl);
    listen_len = CW'(li);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    div_c      = DW'($urandom);
    tx_len     = CW'($urandom);
    blank_len  = CW'($urandom);
    listen_len = CW'($urandom);
    for (int t = 0; t <= last; t++) begin
      {b, t_, l, w, dn} = 5'b00000;
      if (abort_t >= 0 && t > abort_t) begin
        exp_idx = '0;
      end else if (t < tt) begin
        b = 1'b1; t_ = 1'b1;
      end else if (t < tt + bb) begin
        b = 1'b1;
      end else if (t < endt) begin
        b = 1'b1; l = 1'b1;
        k = t - tt - bb;
        if (k % d == d - 1) begin
          w = 1'b1;
          exp_idx = CW'(k / d);
        end
      end else if (t == endt) begin
        b = 1'b1; dn = 1'b1;
      end
      check($sformatf("%s_t%0d", name, t), obs(), pack(b, t_, l, w, dn, 1'b0, exp_idx));
      if (t < last) begin
        start = ign && (t <= endt) && ((t == endt) || ($urandom_range(0, 2) == 0));
        abort = (t == abort_t);
        @(negedge clk);
      end else begin
        start = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  task automatic err_case(input string name, input int d, input int li);
    @(negedge clk);
    check($sformatf("%s_pre", name), obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_idx));
    div_c      = DW'(d);
    listen_len = CW'(li);
    tx_len     = CW'($urandom_range(0, 5));
    blank_len  = CW'($urandom_range(0, 5));
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_pulse", name), obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_idx));
    @(negedge clk);
    check($sformatf("%s_after", name), obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_idx));
  endtask

  initial begin
    int d, tx, bl, li, endt, at;
    rst_n = 1'b0;
    #2;
    check("reset", obs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_ping("basic", 4, 3, 2, 5, -1, 1'b0);
    run_ping("zero_phases", 2, 0, 0, 3, -1, 1'b0);
    err_case("err_div1", 1, 5);
    err_case("err_div0", 0, 3);
    err_case("err_len0", 4, 0);
    // abort held in the cycle after the idx-2 strobe (t = 3+3+9-1 = 14)
    run_ping("abort", 3, 1, 1, 10, 15, 1'b0);
    run_ping("post_abort", 4, 3, 2, 5, -1, 1'b0);
    run_ping("ignored_start", 4, 3, 2, 5, -1, 1'b1);

    @(negedge clk);
    div_c = 8'd3; tx_len = 12'd6; blank_len = 12'd1; listen_len = 12'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_tx", obs(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_idx));
    #2 rst_n = 1'b0;
    #1;
    exp_idx = '0;
    check("async_rst", obs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", obs(), 32'd0);
    run_ping("after_rst", 3, 2, 1, 2, -1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      d    = int'($urandom_range(2, 5));
      tx   = int'($urandom_range(0, 3));
      bl   = int'($urandom_range(0, 3));
      li   = int'($urandom_range(1, 6));
      endt = (tx + bl + li) * d;
      at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, endt - 1)) : -1;
      run_ping($sformatf("rnd%0d", n), d, tx, bl, li, at, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
